// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO on a valid/ready write port feeding
// an LSB-first serialiser. Back-to-back frames are sent without an idle gap.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 142,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [7:0]                    tx_data_in,
  input  logic                          tx_valid_in,
  output logic                          tx_ready_out,
  output logic                          tx_out,
  output logic                          tx_busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [7:0]          mem [FIFO_DEPTH];
  logic                push;
  logic                pop;
  logic                fifo_nonempty;

  assign tx_ready_out   = (count_q != CNT_FULL);
  assign tx_out         = tx_q;
  assign tx_busy_out    = busy_q;
  assign fifo_count_out = count_q;

  assign push          = tx_valid_in & tx_ready_out;
  assign fifo_nonempty = (count_q != '0);

  // Next-state logic: baud/bit sequencing and FIFO pop at frame boundaries
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          bit_d  = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level for the upcoming cycle, so tx_out is a plain register
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

  // Queue occupancy: simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM, serialiser and FIFO pointer registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != ST_IDLE);
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk_in) begin
    if (!rst_in && push) mem[wr_ptr_q] <= tx_data_in;
  end

endmodule
